// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control scheduler: bundle widths, field
// positions inside each control bundle, forwarding select codes and stage records.
package pipe_pkg;

    localparam int WB_W  = 2;
    localparam int M_W   = 3;
    localparam int EX_W  = 5;
    localparam int REG_W = 5;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_MEMWRITE  = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_BRANCH    = 0;
    localparam int EX_ALUSRC   = 4;
    localparam int EX_ALUOP_HI = 3;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_REGDST   = 0;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [M_W-1:0]   m;
        logic [EX_W-1:0]  ex;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [M_W-1:0]   m;
        logic [REG_W-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [REG_W-1:0] dest;
    } memwb_t;

    // A producer only matters if it writes a real register (not $0) equal to src.
    function automatic logic reg_hit(input logic             regwrite,
                                     input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] src);
        return regwrite && (dest != {REG_W{1'b0}}) && (dest == src);
    endfunction

    function automatic logic [1:0] fwd_pick(input logic [REG_W-1:0] src,
                                            input logic             exmem_rw,
                                            input logic [REG_W-1:0] exmem_dest,
                                            input logic             memwb_rw,
                                            input logic [REG_W-1:0] memwb_dest);
        logic [1:0] sel;
        if (reg_hit(exmem_rw, exmem_dest, src)) begin
            sel = FWD_EXMEM;
        end else if (reg_hit(memwb_rw, memwb_dest, src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sched_fwd_unit.sv
// ALU operand forwarding selects for the instruction in EX; the younger
// producer (EX/MEM) wins over MEM/WB. Only built when FORWARD_EN is defined.
`ifdef FORWARD_EN
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] idex_rs,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] exmem_dest,
    input  logic             memwb_regwrite,
    input  logic [REG_W-1:0] memwb_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // Operand A follows rs, operand B follows rt, same priority rule for both.
    always_comb begin
        fwd_a = fwd_pick(idex_rs, exmem_regwrite, exmem_dest, memwb_regwrite, memwb_dest);
        fwd_b = fwd_pick(idex_rt, exmem_regwrite, exmem_dest, memwb_regwrite, memwb_dest);
    end

endmodule
`endif

// File: rtl/pipe_ctrl_sched.sv
// Control-bundle sequencer for the 5-stage MIPS pipeline: hazard stalls, branch
// flush, forwarding selects and saturating stall/flush counters. FORWARD_EN enables forwarding.
module pipe_ctrl_sched
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WB_W-1:0]  id_wb,
    input  logic [M_W-1:0]   id_m,
    input  logic [EX_W-1:0]  id_ex,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             mem_zero,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pc_src,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic [M_W-1:0]   mem_ctrl,
    output logic [WB_W-1:0]  wb_ctrl,
    output logic [REG_W-1:0] ex_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    idex_t            idex_q,  idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [REG_W-1:0] ex_dest_s;
    logic             idex_hit_s;
    logic             stall_s;
    logic             br_taken_s;

    assign ex_dest_s = idex_q.ex[EX_REGDST] ? idex_q.rd : idex_q.rt;

    // Hazard detection against the older instructions still ahead of ID.
    always_comb begin
        idex_hit_s = reg_hit(idex_q.wb[WB_REGWRITE], ex_dest_s, id_rs)
                   | reg_hit(idex_q.wb[WB_REGWRITE], ex_dest_s, id_rt);
`ifdef FORWARD_EN
        stall_s    = idex_q.m[M_MEMREAD] & idex_hit_s;
`else
        stall_s    = idex_hit_s
                   | reg_hit(exmem_q.wb[WB_REGWRITE], exmem_q.dest, id_rs)
                   | reg_hit(exmem_q.wb[WB_REGWRITE], exmem_q.dest, id_rt);
`endif
        br_taken_s = exmem_q.m[M_BRANCH] & mem_zero;
    end

    // Front-end enables: a taken branch overrides any stall so the target is fetched.
    always_comb begin
        if (br_taken_s) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end else begin
            pc_write   = ~stall_s;
            ifid_write = ~stall_s;
        end
        ifid_flush = br_taken_s;
        pc_src     = br_taken_s;
    end

    // Next-state of the pipeline registers and saturating event counters.
    always_comb begin
        idex_d      = '0;
        exmem_d     = '0;
        memwb_d     = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (br_taken_s || stall_s) begin
            idex_d = '0;
        end else begin
            idex_d.wb = id_wb;
            idex_d.m  = id_m;
            idex_d.ex = id_ex;
            idex_d.rt = id_rt;
            idex_d.rd = id_rd;
        end

        if (br_taken_s) begin
            exmem_d = '0;
        end else begin
            exmem_d.wb   = idex_q.wb;
            exmem_d.m    = idex_q.m;
            exmem_d.dest = ex_dest_s;
        end

        memwb_d.wb   = exmem_q.wb;
        memwb_d.dest = exmem_q.dest;

        // A stall that coincides with a flush is absorbed by the flush.
        if (br_taken_s) begin
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else if (stall_s) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef FORWARD_EN
    logic [REG_W-1:0] idex_rs_q, idex_rs_d;

    // rs is only needed in EX by the forwarding unit; bubbles carry rs=0.
    always_comb begin
        if (br_taken_s || stall_s) begin
            idex_rs_d = {REG_W{1'b0}};
        end else begin
            idex_rs_d = id_rs;
        end
    end

    // ID/EX rs register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_rs_q <= {REG_W{1'b0}};
        end else begin
            idex_rs_q <= idex_rs_d;
        end
    end

    fwd_unit u_fwd_unit (
        .idex_rs        (idex_rs_q),
        .idex_rt        (idex_q.rt),
        .exmem_regwrite (exmem_q.wb[WB_REGWRITE]),
        .exmem_dest     (exmem_q.dest),
        .memwb_regwrite (memwb_q.wb[WB_REGWRITE]),
        .memwb_dest     (memwb_q.dest),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );
`else
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    assign ex_ctrl   = idex_q.ex;
    assign mem_ctrl  = exmem_q.m;
    assign wb_ctrl   = memwb_q.wb;
    assign ex_dest   = ex_dest_s;
    assign mem_dest  = exmem_q.dest;
    assign wb_dest   = memwb_q.dest;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
